// File: rtl/ysyx_23060191_mdu_pkg.sv
// rtl/ysyx_23060191_mdu_pkg.sv - shared MDU opcode and FSM state encodings
package ysyx_23060191_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // rs1 is treated as signed by these ops
  function automatic logic op_signed_rs1(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_signed_rs2(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ysyx_23060191_mdu_divcore.sv
// rtl/ysyx_23060191_mdu_divcore.sv - 32-step restoring divider on unsigned operands
module ysyx_23060191_mdu_divcore #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [4:0]      cnt;
  logic            busy;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // quo doubles as the dividend shift register: its MSB feeds the remainder
  assign shifted   = {rem, quo[XLEN-1]};
  assign trial     = shifted - {1'b0, dvsr};
  assign done      = busy && (cnt == 5'd31);
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (kill) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (!trial[XLEN]) begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060191_mdu.sv
// rtl/ysyx_23060191_mdu.sv - iterative RV32M multiply/divide unit
module ysyx_23060191_mdu
  import ysyx_23060191_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] mdu_in1,
  input  logic [XLEN-1:0] mdu_in2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_res
);

  mdu_state_e state, state_n;
  mdu_op_e    op_in, op_q;

  logic              hs, s1, s2, div_zero, div_ovf, bypass, calc_last, div_done;
  logic              neg_q, byp_q;
  logic [XLEN-1:0]   a_abs, b_abs, byp_val, byp_val_q, mcand;
  logic [XLEN-1:0]   quotient, remainder, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN:0]     mul_sum;
  logic [4:0]        cnt;

  assign op_in     = mdu_op_e'(mdu_op);
  assign in_ready  = (state == MDU_IDLE);
  assign out_valid = (state == MDU_DONE);
  assign hs        = in_valid && in_ready && !flush;

  assign s1    = mdu_in1[XLEN-1] && op_signed_rs1(op_in);
  assign s2    = mdu_in2[XLEN-1] && op_signed_rs2(op_in);
  assign a_abs = s1 ? -mdu_in1 : mdu_in1;
  assign b_abs = s2 ? -mdu_in2 : mdu_in2;

  assign div_zero = op_in[2] && (mdu_in2 == '0);
  assign div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                    (mdu_in1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_in2 == '1);
  assign bypass   = div_zero || div_ovf;
  // op[1] selects REM/REMU within the divide group
  assign byp_val  = div_zero ? (op_in[1] ? mdu_in1 : '1) : (op_in[1] ? '0 : mdu_in1);

  // shift-add step: add multiplicand to the high half, shift the whole product right
  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
  assign calc_last = op_q[2] ? div_done : (cnt == 5'd31);

  ysyx_23060191_mdu_divcore #(.XLEN(XLEN)) u_divcore (
    .clk       (clk),
    .rst       (rst),
    .kill      (flush),
    .start     (hs && op_in[2] && !bypass),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = MDU_IDLE;
    end else begin
      case (state)
        MDU_IDLE: if (in_valid) state_n = bypass ? MDU_DONE : MDU_CALC;
        MDU_CALC: if (calc_last) state_n = MDU_DONE;
        MDU_DONE: if (out_ready) state_n = MDU_IDLE;
        default:  state_n = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= MDU_MUL;
      prod      <= '0;
      mcand     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      byp_q     <= 1'b0;
      byp_val_q <= '0;
    end else if (hs) begin
      op_q      <= op_in;
      prod      <= {{XLEN{1'b0}}, a_abs};
      mcand     <= b_abs;
      cnt       <= '0;
      neg_q     <= (op_in == MDU_REM) ? s1 : (s1 ^ s2);
      byp_q     <= bypass;
      byp_val_q <= byp_val;
    end else if ((state == MDU_CALC) && !flush) begin
      prod <= {mul_sum, prod[XLEN-1:1]};
      cnt  <= cnt + 5'd1;
    end
  end

  // sign correction is applied on the held magnitudes, so the result is stable in DONE
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -quotient : quotient;
  assign rem_fix  = neg_q ? -remainder : remainder;

  always_comb begin
    mdu_res = '0;
    if (byp_q) begin
      mdu_res = byp_val_q;
    end else begin
      case (op_q)
        MDU_MUL:                       mdu_res = prod[XLEN-1:0];
        MDU_MULH, MDU_MULHSU, MDU_MULHU: mdu_res = prod_fix[2*XLEN-1:XLEN];
        MDU_DIV, MDU_DIVU:             mdu_res = quo_fix;
        default:                       mdu_res = rem_fix;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060191_mdu.md
YSYX_23060191_MDU -- requirements
Module: ysyx_23060191_mdu

Interface
REQ-001 SHALL: parameter XLEN, default 32, operand/result width (only 32 supported).
REQ-002 SHALL: clk  input  1  sole clock, rising edge.
REQ-003 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL: in_valid  input  1  request present.
REQ-005 SHALL: in_ready  output  1  unit can accept a request.
REQ-006 SHALL: mdu_op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL: mdu_in1, mdu_in2  input  XLEN  rs1/rs2 operands.
REQ-008 SHALL: flush  input  1  synchronous kill of any in-flight operation.
REQ-009 SHALL: out_valid  output  1  result present.
REQ-010 SHALL: out_ready  input  1  consumer accepts result.
REQ-011 SHALL: mdu_res  output  XLEN  result, stable while out_valid && !out_ready.

Function
REQ-012 SHALL: FSM states IDLE, CALC, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 SHALL: handshake in = in_valid && in_ready at rising edge; operands, op and sign flags latch on that edge; inputs ignored otherwise.
REQ-014 SHALL: IDLE -> CALC on handshake, iteration counter cleared to 0.
REQ-015 SHALL: CALC performs one radix-2 step per cycle (shift-add multiply on 64-bit product; restoring divide on 33-bit partial remainder), operating on absolute values for signed ops.
REQ-016 SHALL: CALC -> DONE on the edge completing iteration 32; out_valid therefore rises 33 cycles after the handshake edge.
REQ-017 SHALL: DONE -> IDLE when out_ready is high; result held indefinitely otherwise (no back-to-back acceptance while in DONE).
REQ-018 SHALL: signed correction in DONE: quotient negated if operand signs differ; remainder takes dividend sign; MULH/MULHSU product negated if effective signs differ.
REQ-019 SHALL: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]; MULHSU treats mdu_in1 signed, mdu_in2 unsigned.
REQ-020 SHALL: divide by zero bypasses CALC (IDLE -> DONE directly, latency 1): DIV/DIVU = 0xFFFFFFFF, REM/REMU = mdu_in1.
REQ-021 SHALL: signed overflow (DIV/REM, in1 = 0x80000000, in2 = 0xFFFFFFFF) bypasses CALC: DIV = 0x80000000, REM = 0.
REQ-022 SHALL: flush in any state forces IDLE on the next edge, out_valid low, result discarded; flush overrides a simultaneous handshake (request not accepted).
REQ-023 SHALL: flush coincident with out_valid && out_ready counts the result as consumed (consumer owns its own kill).

Reset
REQ-024 SHALL: rst asserted forces state IDLE, counter 0, mdu_res 0, in_ready 1, out_valid 0, independent of clk.
REQ-025 SHALL: rst mid-CALC or mid-DONE abandons the operation; no result is ever presented for it after deassertion.
REQ-026 SHALL: first handshake possible on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL: mdu_op encodings and FSM state encodings live in the shared defines file alongside the existing ALU opcode macros.
REQ-028 SHALL: one sub-module ysyx_23060191_mdu_divcore holds the iterative 32-step restoring divider (start, done, quotient, remainder); multiply iteration and sign handling stay in the parent.
REQ-029 SHALL: no multiplier or divider operator in synthesized RTL; all datapath arithmetic is add/subtract/shift.

Verification
REQ-030 SHALL: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001; out_valid at cycle 33.
REQ-031 SHALL: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/2 -> 3, REMU -> 1.
REQ-032 SHALL: DIVU 0x12345678 / 0 -> 0xFFFFFFFF and REM 0x12345678 / 0 -> 0x12345678, out_valid one cycle after handshake.
REQ-033 SHALL: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, latency 1.
REQ-034 SHALL: out_ready held low 10 cycles after out_valid -> mdu_res and out_valid stable, in_ready low throughout; accepted on release, in_ready high next cycle.
REQ-035 SHALL: flush at CALC iteration 15 with in_valid high -> IDLE next edge, no out_valid, request not accepted; async rst pulse mid-CALC -> outputs reset immediately, no stale result.
